// File: rtl/imem_load_run_ctrl.sv
// imem_load_run_ctrl: program lifecycle sequencer for the CPU.
// Packs a byte stream into instruction words, writes them to instruction
// memory, holds the CPU in reset while loading, then runs it until a0 or
// a cycle budget stops it.
module imem_load_run_ctrl #(
    parameter int A_WIDTH   = 32,
    parameter int D_WIDTH   = 32,
    parameter int MEM_WORDS = 256,
    parameter int CNT_WIDTH = 16,
    parameter int RUN_LIMIT = 1024,
    localparam int WC_WIDTH = $clog2(MEM_WORDS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_load_valid,
    input  logic [7:0]           i_load_byte,
    input  logic                 i_load_last,
    output logic                 o_load_ready,
    input  logic                 i_start,
    output logic                 o_mem_we,
    output logic [A_WIDTH-1:0]   o_mem_addr,
    output logic [D_WIDTH-1:0]   o_mem_wdata,
    output logic                 o_cpu_rst,
    input  logic                 i_a0,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_halt_cause,
    output logic [CNT_WIDTH-1:0] o_cycle_count,
    output logic [WC_WIDTH-1:0]  o_word_count,
    output logic                 o_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [WC_WIDTH-1:0]  MEM_WORDS_W = WC_WIDTH'(MEM_WORDS);
    localparam logic [CNT_WIDTH-1:0] RUN_LIMIT_W = CNT_WIDTH'(RUN_LIMIT);
    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_A0    = 2'b01;
    localparam logic [1:0] CAUSE_LIMIT = 2'b10;

    state_t               r_state;
    logic [1:0]           r_byteIdx;
    logic [D_WIDTH-1:0]   r_wordBuf;
    logic                 r_memWe;
    logic [A_WIDTH-1:0]   r_memAddr;
    logic [D_WIDTH-1:0]   r_memWdata;
    logic                 r_cpuRst;
    logic                 r_busy;
    logic                 r_done;
    logic [1:0]           r_haltCause;
    logic [CNT_WIDTH-1:0] r_cycleCount;
    logic [WC_WIDTH-1:0]  r_wordCount;
    logic                 r_overflow;

    logic                 w_loadReady;
    logic                 w_accept;
    logic                 w_wordComplete;
    logic [D_WIDTH-1:0]   w_assembled;
    logic [A_WIDTH-1:0]   w_wordAddr;
    logic [WC_WIDTH-1:0]  w_wcNext;
    logic [CNT_WIDTH-1:0] w_cntNext;

    // The buffer keeps lanes at and above the current byte index zero, so
    // OR-ing the new byte into its lane yields a word with zeroed upper lanes.
    assign w_loadReady    = (r_state == ST_IDLE) && (r_wordCount < MEM_WORDS_W) && !i_clear;
    assign w_accept       = i_load_valid && w_loadReady;
    assign w_wordComplete = (r_byteIdx == 2'd3) || i_load_last;
    assign w_assembled    = r_wordBuf | (D_WIDTH'(i_load_byte) << {r_byteIdx, 3'b000});
    assign w_wordAddr     = A_WIDTH'({r_wordCount, 2'b00});
    assign w_wcNext       = r_wordCount + WC_WIDTH'(1);
    assign w_cntNext      = r_cycleCount + CNT_WIDTH'(1);

    // Lifecycle FSM: packs bytes into words, sequences CPU reset and counts run cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_byteIdx    <= 2'd0;
            r_wordBuf    <= '0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_cpuRst     <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_haltCause  <= CAUSE_NONE;
            r_cycleCount <= '0;
            r_wordCount  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_memWe <= 1'b0;
            if (i_clear) begin
                r_state      <= ST_IDLE;
                r_byteIdx    <= 2'd0;
                r_wordBuf    <= '0;
                r_cpuRst     <= 1'b1;
                r_busy       <= 1'b0;
                r_done       <= 1'b0;
                r_haltCause  <= CAUSE_NONE;
                r_cycleCount <= '0;
                r_wordCount  <= '0;
                r_overflow   <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            if (w_wordComplete) begin
                                r_memWe     <= 1'b1;
                                r_memAddr   <= w_wordAddr;
                                r_memWdata  <= w_assembled;
                                r_wordCount <= w_wcNext;
                                r_byteIdx   <= 2'd0;
                                r_wordBuf   <= '0;
                                if (i_load_last) begin
                                    r_state    <= ST_READY;
                                    r_overflow <= 1'b0;
                                end else if (w_wcNext == MEM_WORDS_W) begin
                                    r_state    <= ST_READY;
                                    r_overflow <= 1'b1;
                                end
                            end else begin
                                r_wordBuf <= w_assembled;
                                r_byteIdx <= r_byteIdx + 2'd1;
                            end
                        end
                    end
                    ST_READY, ST_DONE: begin
                        if (i_start) begin
                            r_state      <= ST_RUN;
                            r_cpuRst     <= 1'b0;
                            r_busy       <= 1'b1;
                            r_done       <= 1'b0;
                            r_cycleCount <= '0;
                            r_haltCause  <= CAUSE_NONE;
                        end
                    end
                    ST_RUN: begin
                        r_cycleCount <= w_cntNext;
                        if (i_a0) begin
                            r_state     <= ST_DONE;
                            r_cpuRst    <= 1'b1;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_haltCause <= CAUSE_A0;
                        end else if (w_cntNext == RUN_LIMIT_W) begin
                            r_state     <= ST_DONE;
                            r_cpuRst    <= 1'b1;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_haltCause <= CAUSE_LIMIT;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_load_ready  = w_loadReady;
    assign o_mem_we      = r_memWe;
    assign o_mem_addr    = r_memAddr;
    assign o_mem_wdata   = r_memWdata;
    assign o_cpu_rst     = r_cpuRst;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_halt_cause  = r_haltCause;
    assign o_cycle_count = r_cycleCount;
    assign o_word_count  = r_wordCount;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_imem_load_run_ctrl.sv
// tb_imem_load_run_ctrl: table vectors for the basic load/run path, hand
// sequences for overflow, halt causes, clear and async reset, then random
// streams and runs scored against a word-level model of the loader.
module tb_imem_load_run_ctrl;

    localparam int A_WIDTH   = 32;
    localparam int D_WIDTH   = 32;
    localparam int MEM_WORDS = 4;
    localparam int CNT_WIDTH = 16;
    localparam int RUN_LIMIT = 16;
    localparam int WC_WIDTH  = $clog2(MEM_WORDS + 1);
    localparam int MAX_BYTES = MEM_WORDS * 4;

    logic                 clk;
    logic                 rst_n;
    logic                 clear;
    logic                 loadValid;
    logic [7:0]           loadByte;
    logic                 loadLast;
    logic                 loadReady;
    logic                 start;
    logic                 memWe;
    logic [A_WIDTH-1:0]   memAddr;
    logic [D_WIDTH-1:0]   memWdata;
    logic                 cpuRst;
    logic                 a0;
    logic                 busy;
    logic                 done;
    logic [1:0]           haltCause;
    logic [CNT_WIDTH-1:0] cycleCount;
    logic [WC_WIDTH-1:0]  wordCount;
    logic                 overflow;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] wAddrQ[$];
    logic [31:0] wDataQ[$];
    logic [7:0]  streamBytes[0:63];

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  data;
        logic        lst;
        logic        st;
        logic        a;
        logic        expReady;
        logic        expWe;
        logic [31:0] expAddr;
        logic [31:0] expData;
        int          expWc;
        logic        expCpuRst;
        logic        expBusy;
        logic        expDone;
        logic [1:0]  expCause;
        int          expCnt;
    } vec_t;

    vec_t vecs[$];

    imem_load_run_ctrl #(
        .A_WIDTH  (A_WIDTH),
        .D_WIDTH  (D_WIDTH),
        .MEM_WORDS(MEM_WORDS),
        .CNT_WIDTH(CNT_WIDTH),
        .RUN_LIMIT(RUN_LIMIT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_load_valid (loadValid),
        .i_load_byte  (loadByte),
        .i_load_last  (loadLast),
        .o_load_ready (loadReady),
        .i_start      (start),
        .o_mem_we     (memWe),
        .o_mem_addr   (memAddr),
        .o_mem_wdata  (memWdata),
        .o_cpu_rst    (cpuRst),
        .i_a0         (a0),
        .o_busy       (busy),
        .o_done       (done),
        .o_halt_cause (haltCause),
        .o_cycle_count(cycleCount),
        .o_word_count (wordCount),
        .o_overflow   (overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (memWe === 1'b1) begin
            wAddrQ.push_back(memAddr);
            wDataQ.push_back(memWdata);
        end
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void addVec(input logic clr, input logic vld, input logic [7:0] d,
                                   input logic lst, input logic st, input logic a,
                                   input logic rdy, input logic we, input logic [31:0] addr,
                                   input logic [31:0] data, input int wc, input logic cpu,
                                   input logic bsy, input logic dn, input logic [1:0] cause,
                                   input int cnt);
        vec_t v;
        v.clr = clr; v.vld = vld; v.data = d; v.lst = lst; v.st = st; v.a = a;
        v.expReady = rdy; v.expWe = we; v.expAddr = addr; v.expData = data;
        v.expWc = wc; v.expCpuRst = cpu; v.expBusy = bsy; v.expDone = dn;
        v.expCause = cause; v.expCnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input vec_t v);
        clear     = v.clr;
        loadValid = v.vld;
        loadByte  = v.data;
        loadLast  = v.lst;
        start     = v.st;
        a0        = v.a;
    endtask

    task automatic checkVector(input int i, input vec_t v);
        checkOutput($sformatf("vec%0d.ready", i), 64'(loadReady), 64'(v.expReady));
        checkOutput($sformatf("vec%0d.we", i), 64'(memWe), 64'(v.expWe));
        if (v.expWe) begin
            checkOutput($sformatf("vec%0d.addr", i), 64'(memAddr), 64'(v.expAddr));
            checkOutput($sformatf("vec%0d.wdata", i), 64'(memWdata), 64'(v.expData));
        end
        checkOutput($sformatf("vec%0d.wordCount", i), 64'(wordCount), 64'(v.expWc));
        checkOutput($sformatf("vec%0d.cpuRst", i), 64'(cpuRst), 64'(v.expCpuRst));
        checkOutput($sformatf("vec%0d.busy", i), 64'(busy), 64'(v.expBusy));
        checkOutput($sformatf("vec%0d.done", i), 64'(done), 64'(v.expDone));
        checkOutput($sformatf("vec%0d.cause", i), 64'(haltCause), 64'(v.expCause));
        checkOutput($sformatf("vec%0d.cycles", i), 64'(cycleCount), 64'(v.expCnt));
    endtask

    task automatic idleInputs();
        clear = 1'b0; loadValid = 1'b0; loadByte = 8'h00; loadLast = 1'b0;
        start = 1'b0; a0 = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".ready"}, 64'(loadReady), 64'd1);
        checkOutput({tag, ".we"}, 64'(memWe), 64'd0);
        checkOutput({tag, ".addr"}, 64'(memAddr), 64'd0);
        checkOutput({tag, ".wdata"}, 64'(memWdata), 64'd0);
        checkOutput({tag, ".cpuRst"}, 64'(cpuRst), 64'd1);
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".done"}, 64'(done), 64'd0);
        checkOutput({tag, ".cause"}, 64'(haltCause), 64'd0);
        checkOutput({tag, ".cycles"}, 64'(cycleCount), 64'd0);
        checkOutput({tag, ".wordCount"}, 64'(wordCount), 64'd0);
        checkOutput({tag, ".overflow"}, 64'(overflow), 64'd0);
    endtask

    task automatic clearDut();
        idleInputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        wAddrQ.delete();
        wDataQ.delete();
    endtask

    // Offer k bytes from streamBytes; bytes refused by load_ready are dropped.
    task automatic sendStream(input int k, input bit lastFlag, input int gapPct);
        for (int i = 0; i < k; i++) begin
            if (int'($urandom_range(0, 99)) < gapPct) begin
                loadValid = 1'b0;
                loadLast  = 1'b0;
                tick();
            end
            loadValid = 1'b1;
            loadByte  = streamBytes[i];
            loadLast  = lastFlag && (i == k - 1);
            if (loadReady) tick();
        end
        loadValid = 1'b0;
        loadLast  = 1'b0;
        tick();
        tick();
    endtask

    // Word-level model: group accepted bytes into little-endian words.
    task automatic verifyLoad(input int k, input bit lastFlag, input string tag, output bit finished);
        int          accepted;
        bit          lastSeen;
        int          nWords;
        logic [31:0] word;
        accepted = (k > MAX_BYTES) ? MAX_BYTES : k;
        lastSeen = lastFlag && (k <= MAX_BYTES);
        finished = lastSeen || (accepted == MAX_BYTES);
        nWords   = lastSeen ? (accepted + 3) / 4 : accepted / 4;
        checkOutput({tag, ".writes"}, 64'(wAddrQ.size()), 64'(nWords));
        for (int w = 0; w < nWords && w < wAddrQ.size(); w++) begin
            word = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * w + j < accepted) word = word | (32'(streamBytes[4 * w + j]) << (8 * j));
            end
            checkOutput($sformatf("%s.addr%0d", tag, w), 64'(wAddrQ[w]), 64'(4 * w));
            checkOutput($sformatf("%s.data%0d", tag, w), 64'(wDataQ[w]), 64'(word));
        end
        checkOutput({tag, ".wordCount"}, 64'(wordCount), 64'(nWords));
        checkOutput({tag, ".overflow"}, 64'(overflow), 64'(finished && !lastSeen));
        checkOutput({tag, ".ready"}, 64'(loadReady), 64'(!finished));
        checkOutput({tag, ".cpuRst"}, 64'(cpuRst), 64'd1);
    endtask

    // Run the loaded program; a0 pulses on RUN cycle t (0 = never).
    task automatic runProgram(input int t, input string tag);
        int         expN;
        logic [1:0] expCause;
        int         low;
        int         j;
        expN     = (t >= 1 && t <= RUN_LIMIT) ? t : RUN_LIMIT;
        expCause = (t >= 1 && t <= RUN_LIMIT) ? 2'b01 : 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput({tag, ".startCycles"}, 64'(cycleCount), 64'd0);
        checkOutput({tag, ".startCause"}, 64'(haltCause), 64'd0);
        checkOutput({tag, ".startBusy"}, 64'(busy), 64'd1);
        checkOutput({tag, ".startDone"}, 64'(done), 64'd0);
        low = 0;
        j   = 1;
        while (!done && j <= RUN_LIMIT + 8) begin
            if (!cpuRst) low++;
            a0 = (j == t);
            tick();
            j++;
        end
        a0 = 1'b0;
        checkOutput({tag, ".done"}, 64'(done), 64'd1);
        checkOutput({tag, ".cycles"}, 64'(cycleCount), 64'(expN));
        checkOutput({tag, ".cause"}, 64'(haltCause), 64'(expCause));
        checkOutput({tag, ".cpuLowCycles"}, 64'(low), 64'(expN));
        checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
        checkOutput({tag, ".cpuRst"}, 64'(cpuRst), 64'd1);
        tick();
        checkOutput({tag, ".holdCycles"}, 64'(cycleCount), 64'(expN));
    endtask

    initial begin
        bit finished;
        int k;
        bit lastFlag;
        int t;

        idleInputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkResetValues("reset");
        #5 rst_n = 1'b1;
        tick();

        // clr vld data last start a0 | ready we addr data wc cpuRst busy done cause cycles
        addVec(0, 1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h22, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h33, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h44, 0, 0, 0, 1, 1, 32'h0, 32'h44332211, 1, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h55, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h66, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h77, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'h88, 1, 0, 0, 0, 1, 32'h4, 32'h88776655, 2, 1, 0, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        addVec(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'hA0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'hA1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'hA2, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'hA3, 0, 0, 0, 1, 1, 32'h0, 32'hA3A2A1A0, 1, 1, 0, 0, 2'b00, 0);
        addVec(0, 1, 8'hA4, 1, 0, 0, 0, 1, 32'h4, 32'h000000A4, 2, 1, 0, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 2, 0, 1, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 2'b00, 1);
        addVec(0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 2'b00, 2);
        addVec(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
        addVec(0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkVector(i, vecs[i]);
        end
        idleInputs();
        tick();

        // Overflow: 20 bytes, no last; only four words fit.
        clearDut();
        for (int i = 0; i < 20; i++) streamBytes[i] = 8'(8'h10 + i);
        sendStream(20, 1'b0, 0);
        verifyLoad(20, 1'b0, "overflow", finished);

        // a0 in the 5th RUN cycle, then budget expiry, then re-run from DONE.
        runProgram(5, "a0run");
        runProgram(0, "limitRun");
        runProgram(0, "rerun");
        runProgram(RUN_LIMIT, "a0AtLimit");

        // Last byte completes the final word: full memory but no overflow.
        clearDut();
        for (int i = 0; i < 16; i++) streamBytes[i] = 8'(8'hC0 + i);
        sendStream(16, 1'b1, 0);
        verifyLoad(16, 1'b1, "fullWithLast", finished);

        // Async reset in the middle of a partially assembled word.
        clearDut();
        for (int i = 0; i < 6; i++) streamBytes[i] = 8'(8'h30 + i);
        sendStream(6, 1'b0, 0);
        loadValid = 1'b1;
        loadByte  = 8'hEE;
        #3 rst_n = 1'b0;
        #1;
        checkResetValues("asyncReset");
        loadValid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        wAddrQ.delete();
        wDataQ.delete();
        for (int i = 0; i < 4; i++) streamBytes[i] = 8'(8'h50 + i);
        sendStream(4, 1'b1, 0);
        verifyLoad(4, 1'b1, "afterReset", finished);

        // Random streams and runs against the model.
        for (int it = 0; it < 14; it++) begin
            clearDut();
            k        = int'($urandom_range(1, 22));
            lastFlag = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < k; i++) streamBytes[i] = 8'($urandom);
            sendStream(k, lastFlag, 30);
            verifyLoad(k, lastFlag, $sformatf("rand%0d", it), finished);
            if (finished) begin
                t = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, RUN_LIMIT + 4));
                runProgram(t, $sformatf("rand%0d.run", it));
                t = int'($urandom_range(0, RUN_LIMIT + 4));
                runProgram(t, $sformatf("rand%0d.rerun", it));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
